// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic stall_memwb;
    logic flush_ifid;
    logic flush_idex;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Canned output patterns for each hazard resolution.
  localparam pipe_ctrl_t CTRL_IDLE     = pipe_ctrl_t'(7'b000_0000);
  localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(7'b111_1100);
  localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(7'b000_0011);
  localparam pipe_ctrl_t CTRL_LOADUSE  = pipe_ctrl_t'(7'b110_0001);
  localparam pipe_ctrl_t CTRL_FETCH    = pipe_ctrl_t'(7'b100_0010);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_lu_hit
);

  logic w_rs1_match;
  logic w_rs2_match;

  // x0 never carries a real dependency, so a load targeting it is ignored.
  always_comb begin
    w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    o_lu_hit    = i_ex_mem_read && (i_ex_rd != REG_X0) && (w_rs1_match || w_rs2_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards resolved by priority each cycle
// LU_STALL | extra load-use bubbles still owed; lu_cnt holds how many
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_br_taken_i,
  input  logic             imem_busy_i,
  input  logic             dmem_busy_i,
  output logic             stall_pc_o,
  output logic             stall_ifid_o,
  output logic             stall_idex_o,
  output logic             stall_exmem_o,
  output logic             stall_memwb_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int LU_W = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES + 1) : 1;
  localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [LU_W-1:0]  LU_INIT  = LU_W'(LU_STALL_CYCLES - 1);
  localparam logic [LU_W-1:0]  LU_LAST  = LU_W'(1);
  localparam logic [WT_W-1:0]  WAIT_MAX = WT_W'(MEM_TIMEOUT);
  localparam logic [WT_W-1:0]  WAIT_PRE = WT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        r_state;
  logic [LU_W-1:0]  r_lu_cnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_lu_hit;
  logic             w_redirect;
  pipe_ctrl_t       w_ctrl;

  load_use_detect u_lu_detect (
    .i_id_rs1      (id_rs1_i),
    .i_id_rs2      (id_rs2_i),
    .i_id_rs1_used (id_rs1_used_i),
    .i_id_rs2_used (id_rs2_used_i),
    .i_ex_rd       (ex_rd_i),
    .i_ex_mem_read (ex_mem_read_i),
    .o_lu_hit      (w_lu_hit)
  );

  // Priority mux: freeze beats everything, owed bubbles beat new events,
  // a redirect discards whatever ID held so its load-use hit is moot.
  always_comb begin
    w_ctrl     = CTRL_IDLE;
    w_redirect = 1'b0;
    if (!rst_i) begin
      if (dmem_busy_i) begin
        w_ctrl = CTRL_FREEZE;
      end else if (r_state == LU_STALL) begin
        w_ctrl = CTRL_LOADUSE;
      end else if (ex_br_taken_i) begin
        w_ctrl     = CTRL_REDIRECT;
        w_redirect = 1'b1;
      end else if (w_lu_hit) begin
        w_ctrl = CTRL_LOADUSE;
      end else if (imem_busy_i) begin
        w_ctrl = CTRL_FETCH;
      end
    end
  end

  // Hazard FSM: only multi-cycle load-use stalls need to leave RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= RUN;
      r_lu_cnt <= '0;
    end else if (r_state == RUN) begin
      if (!dmem_busy_i && !ex_br_taken_i && w_lu_hit && (LU_STALL_CYCLES > 1)) begin
        r_state  <= LU_STALL;
        r_lu_cnt <= LU_INIT;
      end
    end else if (!dmem_busy_i) begin
      if (r_lu_cnt == LU_LAST) begin
        r_state  <= RUN;
        r_lu_cnt <= '0;
      end else begin
        r_lu_cnt <= r_lu_cnt - LU_LAST;
      end
    end
  end

  // DMEM busy watchdog: saturating run-length counter plus sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else if (dmem_busy_i) begin
      if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_wait_cnt >= WAIT_PRE) begin
        r_mem_err <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Saturating performance counters for stalled-PC cycles and redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ctrl.stall_pc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_pc_o    = w_ctrl.stall_pc;
  assign stall_ifid_o  = w_ctrl.stall_ifid;
  assign stall_idex_o  = w_ctrl.stall_idex;
  assign stall_exmem_o = w_ctrl.stall_exmem;
  assign stall_memwb_o = w_ctrl.stall_memwb;
  assign flush_ifid_o  = w_ctrl.flush_ifid;
  assign flush_idex_o  = w_ctrl.flush_idex;
  assign mem_err_o     = r_mem_err;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule
